// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue
// Brief    : FIFO between fetch and decode/issue. Holds each fetched
//            instruction with its branch-prediction metadata, presents the
//            oldest entry to decode, and drops everything on a flush.
// Revision : 1.0
// ============================================================================
module issue_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int HLEN  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  // fetch side
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [ILEN-1:0]            instruction_i,
  input  logic [XLEN-1:0]            pred_pc_i,
  input  logic [HLEN-1:0]            pred_index_i,
  input  logic [XLEN-1:0]            pred_target_i,
  input  logic                       pred_taken_i,
  // decode side
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [ILEN-1:0]            instruction_o,
  output logic [XLEN-1:0]            pred_pc_o,
  output logic [HLEN-1:0]            pred_index_o,
  output logic [XLEN-1:0]            pred_target_o,
  output logic                       pred_taken_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  // Entry storage, one array per field so each maps to a plain register file.
  logic [ILEN-1:0] instr_q  [DEPTH];
  logic [XLEN-1:0] pc_q     [DEPTH];
  logic [HLEN-1:0] index_q  [DEPTH];
  logic [XLEN-1:0] target_q [DEPTH];
  logic            taken_q  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic do_push;
  logic do_pop;

  // Handshake flags come only from registered occupancy, so decode's ready
  // never reaches fetch combinationally.
  assign fetch_ready_o = (count_q != C_FULL);
  assign issue_valid_o = (count_q != '0);
  assign count_o       = count_q;

  // A flush cancels any transfer attempted in the same cycle.
  assign do_push = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign do_pop  = issue_valid_o & issue_ready_i & ~flush_i;

  // Head of queue drives decode directly; no fall-through from the fetch side.
  assign instruction_o = instr_q[rd_ptr_q];
  assign pred_pc_o     = pc_q[rd_ptr_q];
  assign pred_index_o  = index_q[rd_ptr_q];
  assign pred_target_o = target_q[rd_ptr_q];
  assign pred_taken_o  = taken_q[rd_ptr_q];

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write; storage is cleared by reset so the idle head reads as zero,
  // but a flush leaves stale contents in place (they are masked by valid).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i]  <= '0;
        pc_q[i]     <= '0;
        index_q[i]  <= '0;
        target_q[i] <= '0;
        taken_q[i]  <= 1'b0;
      end
    end else if (do_push) begin
      instr_q[wr_ptr_q]  <= instruction_i;
      pc_q[wr_ptr_q]     <= pred_pc_i;
      index_q[wr_ptr_q]  <= pred_index_i;
      target_q[wr_ptr_q] <= pred_target_i;
      taken_q[wr_ptr_q]  <= pred_taken_i;
    end
  end

endmodule
`default_nettype wire

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- FIFO buffer between fetch_stage and the decode/issue stage.
- Accepts one fetched instruction plus its branch-prediction metadata per cycle via a valid/ready handshake.
- Presents the oldest entry to decode via a second valid/ready handshake.
- Decouples fetch from decode stalls. On flush (mispredict/exception), all buffered entries are dropped.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 32, address width.
- ILEN, 32, instruction width.
- HLEN, 4, branch history/predictor index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- flush_i  in  1  discard all entries.
- fetch_valid_i  in  1  fetch presents an instruction.
- fetch_ready_o  out  1  queue can accept (drives fetch_stage issue_ready).
- instruction_i  in  ILEN  fetched instruction.
- pred_pc_i  in  XLEN  PC of the instruction.
- pred_index_i  in  HLEN  predictor index.
- pred_target_i  in  XLEN  predicted target.
- pred_taken_i  in  1  predicted taken.
- issue_valid_o  out  1  head entry valid.
- issue_ready_i  in  1  decode accepts head.
- instruction_o  out  ILEN  head instruction.
- pred_pc_o  out  XLEN  head PC.
- pred_index_o  out  HLEN  head predictor index.
- pred_target_o  out  XLEN  head predicted target.
- pred_taken_o  out  1  head predicted taken.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits each, wrapping modulo DEPTH, plus a count register of $clog2(DEPTH)+1 bits.
- Reset (rst_n_i low, asynchronous): pointers = 0, count = 0, all storage = 0. Outputs: issue_valid_o = 0, all data outputs = 0, count_o = 0, fetch_ready_o = 1.
- push = fetch_valid_i & fetch_ready_o & ~flush_i.
- pop = issue_valid_o & issue_ready_i & ~flush_i.
- fetch_ready_o = (count != DEPTH). It is a function of registered state only and never depends on issue_ready_i, so there is no combinational path from decode to fetch.
- issue_valid_o = (count != 0).
- Data outputs are driven combinationally from entry[rd_ptr]. Contents are meaningful only while issue_valid_o = 1.
- Latency: no fall-through. An entry pushed at edge N is visible at the outputs after edge N, i.e. minimum one cycle fetch-to-decode. A push into an empty queue raises issue_valid_o the next cycle.
- Push: entry[wr_ptr] <= inputs; wr_ptr++.
- Pop: rd_ptr++.
- Count update: push only: count+1. Pop only: count-1. Both: unchanged.
- Full: fetch_ready_o = 0, so no push occurs even if a pop happens in the same cycle. Ready reasserts the cycle after the pop.
- Simultaneous push and pop with 0 < count < DEPTH: both occur, count is unchanged, FIFO order is preserved.
- Empty: pop is impossible since issue_valid_o = 0; issue_ready_i is ignored.
- Flush (synchronous, highest priority): at the next edge rd_ptr = wr_ptr = 0 and count = 0. Any same-cycle push or pop is dropped. Storage contents are not cleared.
- After a flush cycle: issue_valid_o = 0, fetch_ready_o = 1.
- Protocol rules:
  - Once fetch_valid_i is asserted, fetch holds its inputs stable until accepted, unless a flush intervenes.
  - The queue holds head outputs stable while issue_valid_o = 1 and issue_ready_i = 0.
- Reset asserted mid-operation: immediate return to reset state; all entries are lost.

Test Plan:
- Reset, then fetch_valid_i = 1 with instruction_i = 1,2,3,4 on consecutive cycles, issue_ready_i = 0. Required: count_o goes 1,2,3,4; fetch_ready_o = 0 after the 4th push; instruction 5 held at input is not accepted.
- From full, issue_ready_i = 1 for 4 cycles with no new pushes. Required: instruction_o = 1,2,3,4 in order; fetch_ready_o = 1 after the first pop; issue_valid_o = 0 after the 4th pop; count_o = 0.
- Continuous streaming with both valid and ready = 1 for 10 cycles, instruction_i = 0x10..0x19. Required: after a one-cycle startup, count_o stays 1; outputs 0x10..0x19 in order; pointers wrap twice with no loss or duplication.
- Push 3 entries, then assert flush_i for one cycle together with fetch_valid_i = 1 (instruction 0xAA) and issue_ready_i = 1. Required: next cycle count_o = 0, issue_valid_o = 0, and 0xAA never appears at the outputs.
- Push an entry with pred_pc = 0x100, pred_target = 0x200, pred_taken = 1, pred_index = 0x5. Required: the popped entry carries identical metadata; while issue_ready_i = 0 the head outputs stay stable.
- Deassert rst_n_i asynchronously (mid-cycle) with 2 entries queued. Required: issue_valid_o = 0, count_o = 0 and data outputs = 0 immediately, without waiting for a clock edge.
